// File: rtl/sm_rf_wb_arbiter_pkg.sv
// Shared widths, register-file constants and request record for the
// register-file writeback path.
package sm_rf_pkg;

    localparam int ADDR_W  = 4;
    localparam int DATA_W  = 32;
    localparam int NUM_GPR = 15;
    localparam logic [ADDR_W-1:0] PC_REG = 4'd15;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    // One-hot scoreboard mask for a register; R15 shifts out and maps to zero.
    function automatic logic [NUM_GPR-1:0] reg_onehot(input logic [ADDR_W-1:0] a);
        return NUM_GPR'(1) << a;
    endfunction

    function automatic logic reg_busy(input logic [NUM_GPR-1:0] b,
                                      input logic [ADDR_W-1:0]  a);
        return |(b & reg_onehot(a));
    endfunction

endpackage

// File: rtl/sm_rf_wb_arbiter_if.sv
// Writeback request bus: per-requester valid/ready handshake with flat
// address and data vectors.
interface sm_rf_wb_arbiter_if #(parameter int N_REQ = 3);
    import sm_rf_pkg::*;

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;

    modport master (output req_valid, req_addr, req_data, input req_ready);
    modport slave  (input req_valid, req_addr, req_data, output req_ready);

endinterface

// File: rtl/sm_rr_arbiter.sv
// Combinational round-robin arbiter: the first asserted request at or after
// ptr (wrapping) wins; the pointer register lives with the caller.
module sm_rr_arbiter #(
    parameter  int N     = 3,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        grant     = '0;
        grant_idx = '0;
        // Walk from farthest to nearest so the candidate closest to ptr is written last.
        for (int k = N - 1; k >= 0; k--) begin
            int j;
            j = (int'(ptr) + k) % N;
            if (req[j]) begin
                grant     = '0;
                grant[j]  = 1'b1;
                grant_idx = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/sm_rf_wb_arbiter.sv
// Round-robin writeback arbiter for the single register-file write port,
// with a busy scoreboard for issue-stage hazards and R15 redirected to the PC.
module sm_rf_wb_arbiter
    import sm_rf_pkg::*;
#(
    parameter int N_REQ = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    sm_rf_wb_arbiter_if.slave   wb,
    input  logic                rsv_valid,
    input  logic [ADDR_W-1:0]   rsv_addr,
    output logic                rsv_ready,
    input  logic                flush,
    input  logic [ADDR_W-1:0]   read_adress0,
    input  logic [ADDR_W-1:0]   read_adress1,
    input  logic [ADDR_W-1:0]   read_adress2,
    output logic [2:0]          rd_hazard,
    output logic [NUM_GPR-1:0]  busy,
    output logic [ADDR_W-1:0]   write_adress3,
    output logic [DATA_W-1:0]   write_data3,
    output logic                write_enable3,
    output logic                pc_wr_valid,
    output logic [DATA_W-1:0]   pc_wr_data
);

    localparam int IDX_W = $clog2(N_REQ);

    logic [N_REQ-1:0]   grant;
    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W-1:0]   rr_ptr;
    logic               any_grant;
    logic               sel_is_pc;
    wb_req_t            sel;
    logic [NUM_GPR-1:0] busy_nxt;

    sm_rr_arbiter #(.N(N_REQ)) u_arb (
        .req       (wb.req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign wb.req_ready = grant;
    assign any_grant    = |grant;
    assign sel.addr     = wb.req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
    assign sel.data     = wb.req_data[int'(grant_idx)*DATA_W +: DATA_W];
    assign sel_is_pc    = (sel.addr == PC_REG);

    // R15 is never tracked, so reg_busy() reports it idle and reservations pass.
    assign rsv_ready = rsv_valid && !flush && !reg_busy(busy, rsv_addr);

    assign rd_hazard = {reg_busy(busy, read_adress2),
                        reg_busy(busy, read_adress1),
                        reg_busy(busy, read_adress0)};

    // Commit clears before the reservation sets, so a reserve of an idle register wins.
    assign busy_nxt = (busy & ~(write_enable3 ? reg_onehot(write_adress3) : '0))
                    | (rsv_ready ? reg_onehot(rsv_addr) : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr        <= '0;
            busy          <= '0;
            write_enable3 <= 1'b0;
            write_adress3 <= '0;
            write_data3   <= '0;
            pc_wr_valid   <= 1'b0;
            pc_wr_data    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            busy          <= flush ? '0 : busy_nxt;
            write_enable3 <= any_grant && !sel_is_pc;
            pc_wr_valid   <= any_grant && sel_is_pc;
            if (any_grant) begin
                rr_ptr <= (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + 1'b1;
                if (sel_is_pc) begin
                    pc_wr_data <= sel.data;
                end else begin
                    write_adress3 <= sel.addr;
                    write_data3   <= sel.data;
                end
            end
        end
    end

endmodule

// File: tb/tb_sm_rf_wb_arbiter.sv
// Bench for sm_rf_wb_arbiter: reset sequence, a directed vector table and
// randomized traffic against a behavioural model of the arbiter and scoreboard.
module tb_sm_rf_wb_arbiter;
    import sm_rf_pkg::*;

    localparam int N = 3;
    localparam logic [31:0] D  = 32'hCAFE_0000;
    localparam logic [31:0] D1 = 32'hDAFE_0000;
    localparam logic [31:0] D2 = 32'hEAFE_0000;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sm_rf_wb_arbiter_if #(.N_REQ(N)) wb();

    logic        rsv_valid, rsv_ready, flush;
    logic [3:0]  rsv_addr, read_adress0, read_adress1, read_adress2;
    logic [2:0]  rd_hazard;
    logic [14:0] busy;
    logic [3:0]  write_adress3;
    logic [31:0] write_data3, pc_wr_data;
    logic        write_enable3, pc_wr_valid;

    sm_rf_wb_arbiter #(.N_REQ(N)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wb            (wb),
        .rsv_valid     (rsv_valid),
        .rsv_addr      (rsv_addr),
        .rsv_ready     (rsv_ready),
        .flush         (flush),
        .read_adress0  (read_adress0),
        .read_adress1  (read_adress1),
        .read_adress2  (read_adress2),
        .rd_hazard     (rd_hazard),
        .busy          (busy),
        .write_adress3 (write_adress3),
        .write_data3   (write_data3),
        .write_enable3 (write_enable3),
        .pc_wr_valid   (pc_wr_valid),
        .pc_wr_data    (pc_wr_data)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One directed cycle: inputs, then expected combinational outputs and the
    // registered outputs visible during that cycle.
    typedef struct packed {
        logic [2:0]  v;
        logic [3:0]  a0, a1, a2;
        logic [31:0] d;
        logic        rv;
        logic [3:0]  ra;
        logic        fl;
        logic [3:0]  r0, r1, r2;
        logic [2:0]  e_rdy;
        logic        e_rr;
        logic [2:0]  e_hz;
        logic [14:0] e_busy;
        logic        e_we;
        logic [3:0]  e_wa;
        logic [31:0] e_wd;
        logic        e_pv;
        logic [31:0] e_pd;
    } vec_t;

    function automatic vec_t mk(
        input logic [2:0] v, input logic [3:0] a0, a1, a2, input logic [31:0] d,
        input logic rv, input logic [3:0] ra, input logic fl,
        input logic [3:0] r0, r1, r2,
        input logic [2:0] e_rdy, input logic e_rr, input logic [2:0] e_hz,
        input logic [14:0] e_busy, input logic e_we, input logic [3:0] e_wa,
        input logic [31:0] e_wd, input logic e_pv, input logic [31:0] e_pd);
        vec_t r;
        r.v = v; r.a0 = a0; r.a1 = a1; r.a2 = a2; r.d = d;
        r.rv = rv; r.ra = ra; r.fl = fl; r.r0 = r0; r.r1 = r1; r.r2 = r2;
        r.e_rdy = e_rdy; r.e_rr = e_rr; r.e_hz = e_hz; r.e_busy = e_busy;
        r.e_we = e_we; r.e_wa = e_wa; r.e_wd = e_wd; r.e_pv = e_pv; r.e_pd = e_pd;
        return r;
    endfunction

    task automatic drive_idle();
        wb.req_valid = '0; wb.req_addr = '0; wb.req_data = '0;
        rsv_valid = 1'b0; rsv_addr = '0; flush = 1'b0;
        read_adress0 = '0; read_adress1 = '0; read_adress2 = '0;
    endtask

    task automatic check_regs(input string tag, input logic [14:0] e_busy,
                              input logic e_we, input logic [3:0] e_wa, input logic [31:0] e_wd,
                              input logic e_pv, input logic [31:0] e_pd);
        check({tag, " busy"}, 32'(busy), 32'(e_busy));
        check({tag, " we3"}, 32'(write_enable3), 32'(e_we));
        check({tag, " pc_valid"}, 32'(pc_wr_valid), 32'(e_pv));
        if (e_we) begin
            check({tag, " wa3"}, 32'(write_adress3), 32'(e_wa));
            check({tag, " wd3"}, write_data3, e_wd);
        end
        if (e_pv) check({tag, " pc_data"}, pc_wr_data, e_pd);
    endtask

    // Reference model: nearest valid requester at or after the pointer, by circular distance.
    function automatic int pick(input logic [N-1:0] v, input int p);
        int best = -1;
        int bd   = N;
        for (int i = 0; i < N; i++) begin
            if (v[i] && ((i - p + N) % N) < bd) begin
                bd   = (i - p + N) % N;
                best = i;
            end
        end
        return best;
    endfunction

    vec_t tbl[$];

    int          m_ptr;
    bit          m_busy[16];
    bit          m_we, m_pv;
    logic [3:0]  m_wa;
    logic [31:0] m_wd, m_pd;
    logic [N-1:0] q_v;
    logic [3:0]  q_a[N];
    logic [31:0] q_d[N];
    int          wcnt[N];

    initial begin
        // Round robin with all three, then with req2 idle.
        tbl.push_back(mk(3'b111,1,2,3,D, 0,0,0, 0,0,0, 3'b001,0,0,15'h0, 0,0,0, 0,0));
        tbl.push_back(mk(3'b111,1,2,3,D, 0,0,0, 0,0,0, 3'b010,0,0,15'h0, 1,1,D, 0,0));
        tbl.push_back(mk(3'b111,1,2,3,D, 0,0,0, 0,0,0, 3'b100,0,0,15'h0, 1,2,D1,0,0));
        tbl.push_back(mk(3'b111,1,2,3,D, 0,0,0, 0,0,0, 3'b001,0,0,15'h0, 1,3,D2,0,0));
        tbl.push_back(mk(3'b111,1,2,3,D, 0,0,0, 0,0,0, 3'b010,0,0,15'h0, 1,1,D, 0,0));
        tbl.push_back(mk(3'b111,1,2,3,D, 0,0,0, 0,0,0, 3'b100,0,0,15'h0, 1,2,D1,0,0));
        tbl.push_back(mk(3'b011,1,2,3,D, 0,0,0, 0,0,0, 3'b001,0,0,15'h0, 1,3,D2,0,0));
        tbl.push_back(mk(3'b011,1,2,3,D, 0,0,0, 0,0,0, 3'b010,0,0,15'h0, 1,1,D, 0,0));
        tbl.push_back(mk(3'b011,1,2,3,D, 0,0,0, 0,0,0, 3'b001,0,0,15'h0, 1,2,D1,0,0));
        tbl.push_back(mk(3'b011,1,2,3,D, 0,0,0, 0,0,0, 3'b010,0,0,15'h0, 1,1,D, 0,0));
        tbl.push_back(mk(3'b000,0,0,0,D, 0,0,0, 0,0,0, 3'b000,0,0,15'h0, 1,2,D1,0,0));
        // Scoreboard on R5: reserve, double reserve, commit, retry.
        tbl.push_back(mk(3'b000,0,0,0,D, 1,5,0, 5,0,0, 3'b000,1,3'b000,15'h0,  0,0,0, 0,0));
        tbl.push_back(mk(3'b000,0,0,0,D, 1,5,0, 5,0,0, 3'b000,0,3'b001,15'h20, 0,0,0, 0,0));
        tbl.push_back(mk(3'b010,0,5,0,D, 0,0,0, 5,0,0, 3'b010,0,3'b001,15'h20, 0,0,0, 0,0));
        tbl.push_back(mk(3'b000,0,0,0,D, 1,5,0, 5,0,0, 3'b000,0,3'b001,15'h20, 1,5,D1,0,0));
        tbl.push_back(mk(3'b000,0,0,0,D, 1,5,0, 5,0,0, 3'b000,1,3'b000,15'h0,  0,0,0, 0,0));
        // R7 commit colliding with a same-cycle reservation.
        tbl.push_back(mk(3'b000,0,0,0,D, 1,7,0, 0,0,0, 3'b000,1,0,15'h20, 0,0,0, 0,0));
        tbl.push_back(mk(3'b001,7,0,0,D, 0,0,0, 0,0,0, 3'b001,0,0,15'hA0, 0,0,0, 0,0));
        tbl.push_back(mk(3'b000,0,0,0,D, 1,7,0, 0,0,0, 3'b000,0,0,15'hA0, 1,7,D,0,0));
        tbl.push_back(mk(3'b000,0,0,0,D, 1,7,0, 0,0,0, 3'b000,1,0,15'h20, 0,0,0, 0,0));
        // R15 writeback and reservation.
        tbl.push_back(mk(3'b001,15,0,0,32'h100, 1,15,0, 0,15,0, 3'b001,1,3'b000,15'hA0, 0,0,0, 0,0));
        tbl.push_back(mk(3'b000,0,0,0,D, 0,0,0, 5,15,7, 3'b000,0,3'b101,15'hA0, 0,0,0, 1,32'h100));
        // Flush with a same-cycle reservation and an in-flight write.
        tbl.push_back(mk(3'b000,0,0,0,D, 1,1,0, 0,0,0, 3'b000,1,0,15'hA0,  0,0,0, 0,0));
        tbl.push_back(mk(3'b000,0,0,0,D, 1,2,0, 0,0,0, 3'b000,1,0,15'hA2,  0,0,0, 0,0));
        tbl.push_back(mk(3'b000,0,0,0,D, 1,9,0, 0,0,0, 3'b000,1,0,15'hA6,  0,0,0, 0,0));
        tbl.push_back(mk(3'b010,0,2,0,D, 1,4,1, 0,0,0, 3'b010,0,0,15'h2A6, 0,0,0, 0,0));
        tbl.push_back(mk(3'b000,0,0,0,D, 0,0,0, 0,0,0, 3'b000,0,0,15'h0,   1,2,D1,0,0));
        tbl.push_back(mk(3'b000,0,0,0,D, 0,0,0, 0,0,0, 3'b000,0,0,15'h0,   0,0,0, 0,0));

        // Reset state, first write, then reset dropping an in-flight grant.
        rst_n = 1'b0;
        drive_idle();
        repeat (2) @(posedge clk);
        #2;
        check_regs("reset", 15'h0, 1'b0, 4'd0, 32'h0, 1'b0, 32'h0);
        check("reset wa3", 32'(write_adress3), 32'h0);
        check("reset wd3", write_data3, 32'h0);
        #1 rst_n = 1'b1;

        @(posedge clk); #1;
        wb.req_valid = 3'b001; wb.req_addr = 12'h003; wb.req_data[31:0] = 32'hA5A5_A5A5;
        rsv_valid = 1'b1; rsv_addr = 4'd6;
        #1;
        check("first rdy", 32'(wb.req_ready), 32'h1);
        check("first rsv_ready", 32'(rsv_ready), 32'h1);

        @(posedge clk); #1;
        wb.req_valid = 3'b010; wb.req_addr = 12'h040; wb.req_data = {32'h0, 32'h1234, 32'h0};
        rsv_valid = 1'b0;
        #1;
        check_regs("first write", 15'h40, 1'b1, 4'd3, 32'hA5A5_A5A5, 1'b0, 32'h0);
        check("inflight rdy", 32'(wb.req_ready), 32'h2);
        #1 rst_n = 1'b0;
        #1;
        check_regs("async reset", 15'h0, 1'b0, 4'd0, 32'h0, 1'b0, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive_idle();
        #1;
        check_regs("dropped write", 15'h0, 1'b0, 4'd0, 32'h0, 1'b0, 32'h0);

        // Directed vectors.
        for (int i = 0; i < tbl.size(); i++) begin
            string tag;
            vec_t  r;
            r = tbl[i];
            tag = $sformatf("row%0d", i);
            @(posedge clk); #1;
            wb.req_valid = r.v;
            wb.req_addr  = {r.a2, r.a1, r.a0};
            wb.req_data  = {r.d ^ 32'h2000_0000, r.d ^ 32'h1000_0000, r.d};
            rsv_valid = r.rv; rsv_addr = r.ra; flush = r.fl;
            read_adress0 = r.r0; read_adress1 = r.r1; read_adress2 = r.r2;
            #1;
            check({tag, " rdy"}, 32'(wb.req_ready), 32'(r.e_rdy));
            check({tag, " rsv_ready"}, 32'(rsv_ready), 32'(r.e_rr));
            check({tag, " hazard"}, 32'(rd_hazard), 32'(r.e_hz));
            check_regs(tag, r.e_busy, r.e_we, r.e_wa, r.e_wd, r.e_pv, r.e_pd);
        end

        // Randomized traffic against the reference model.
        @(posedge clk); #1;
        drive_idle();
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        m_ptr = 0; m_we = 0; m_pv = 0; m_wa = '0; m_wd = '0; m_pd = '0;
        for (int i = 0; i < 16; i++) m_busy[i] = 1'b0;
        q_v = '0;
        for (int i = 0; i < N; i++) begin
            q_a[i] = '0; q_d[i] = '0; wcnt[i] = 0;
        end

        for (int cyc = 0; cyc < 600; cyc++) begin
            string       tag;
            int          g;
            logic [2:0]  e_rdy, e_hz;
            logic        e_rr;
            logic [14:0] e_busy;
            logic [3:0]  ra_k[3];
            tag = $sformatf("rnd%0d", cyc);
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (!q_v[i] && $urandom_range(0, 1) == 1) begin
                    q_v[i]  = 1'b1;
                    q_a[i]  = 4'($urandom_range(0, 15));
                    q_d[i]  = $urandom;
                    wcnt[i] = 0;
                end
                wb.req_addr[i*4 +: 4]   = q_a[i];
                wb.req_data[i*32 +: 32] = q_d[i];
            end
            wb.req_valid = q_v;
            rsv_valid = 1'($urandom_range(0, 1));
            rsv_addr  = 4'($urandom_range(0, 15));
            flush     = ($urandom_range(0, 15) == 0);
            read_adress0 = 4'($urandom_range(0, 15));
            read_adress1 = 4'($urandom_range(0, 15));
            read_adress2 = 4'($urandom_range(0, 15));
            #1;

            g = pick(q_v, m_ptr);
            e_rdy = (g >= 0) ? 3'(1 << g) : 3'b000;
            e_rr  = rsv_valid && !flush && (rsv_addr == 4'd15 || !m_busy[rsv_addr]);
            ra_k[0] = read_adress0; ra_k[1] = read_adress1; ra_k[2] = read_adress2;
            for (int k = 0; k < 3; k++) e_hz[k] = (ra_k[k] != 4'd15) && m_busy[ra_k[k]];
            for (int i = 0; i < 15; i++) e_busy[i] = m_busy[i];

            check({tag, " rdy"}, 32'(wb.req_ready), 32'(e_rdy));
            check({tag, " rsv_ready"}, 32'(rsv_ready), 32'(e_rr));
            check({tag, " hazard"}, 32'(rd_hazard), 32'(e_hz));
            check_regs(tag, e_busy, m_we, m_wa, m_wd, m_pv, m_pd);

            for (int i = 0; i < N; i++) begin
                if (q_v[i]) begin
                    if (wb.req_ready[i]) begin
                        check({tag, " wait bound"}, 32'(wcnt[i] <= N - 1), 32'h1);
                        q_v[i] = 1'b0;
                    end else begin
                        wcnt[i]++;
                    end
                end
            end

            if (flush) begin
                for (int i = 0; i < 16; i++) m_busy[i] = 1'b0;
            end else begin
                if (m_we) m_busy[m_wa] = 1'b0;
                if (e_rr && rsv_addr != 4'd15) m_busy[rsv_addr] = 1'b1;
            end
            if (g >= 0) begin
                if (q_a[g] == 4'd15) begin
                    m_we = 1'b0; m_pv = 1'b1; m_pd = q_d[g];
                end else begin
                    m_we = 1'b1; m_pv = 1'b0; m_wa = q_a[g]; m_wd = q_d[g];
                end
                m_ptr = (g + 1) % N;
            end else begin
                m_we = 1'b0; m_pv = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sm_rf_wb_arbiter.md
Name: sm_rf_wb_arbiter

Overview:
Shares the single register-file write port (write_adress3/write_data3/write_enable3) between N writeback sources: ALU, load unit and multiplier.
- Round-robin arbitration with a valid/ready handshake per requester.
- One registered output stage that drives the register-file write port directly.
- A 15-entry busy scoreboard that the issue stage reserves and writeback clears; it reports read hazards for the three register-file read addresses.
- R15 is the PC and is not stored, so writes to R15 are redirected to a separate PC-write output.

Parameters:
N_REQ, 3, number of writeback requesters (2..8)
DATA_W, 32, data width
ADDR_W, 4, register address width (16 architectural regs, R15 = PC)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  N_REQ  requester i has a write pending
req_addr  in  N_REQ*ADDR_W  destination register, per requester
req_data  in  N_REQ*DATA_W  write data, per requester
req_ready  out  N_REQ  one-hot grant; transfer on valid&&ready
rsv_valid  in  1  issue stage reserves destination rsv_addr
rsv_addr  in  ADDR_W  register to mark busy
rsv_ready  out  1  reservation accepted this cycle
flush  in  1  clear all busy bits (pipeline squash)
read_adress0..2  in  ADDR_W each  same addresses driven to the register file read ports
rd_hazard  out  3  bit k = busy[read_adress_k]
busy  out  15  scoreboard state, R0..R14
write_adress3  out  ADDR_W  to register file
write_data3  out  DATA_W  to register file
write_enable3  out  1  to register file
pc_wr_valid  out  1  writeback targeted R15
pc_wr_data  out  DATA_W  PC value for fetch redirect

Behaviour:
Reset (rst_n=0, async):
- All registered outputs go to 0: write_*3, pc_wr_*, busy.
- rr_ptr = 0.
- Reset mid-transfer drops the in-flight write; no partial write is emitted.

Arbitration:
- Combinational from req_valid and rr_ptr.
- Search starts at index rr_ptr and wraps modulo N_REQ; the first valid wins.
- req_ready is one-hot or zero; it is never asserted to a non-valid requester.
- Output stage always accepts, so a valid requester is granted within N_REQ cycles (no starvation).
- On a grant to i, rr_ptr <= (i+1) mod N_REQ. With no grant, rr_ptr holds.
- Requesters hold addr/data stable while valid && !ready; valid may not drop before ready.

Write stage (1-cycle latency):
- Grant in cycle N produces a registered output in cycle N+1.
- If granted addr != 15: write_enable3=1, write_adress3/write_data3 = granted values, pc_wr_valid=0.
- If granted addr == 15: write_enable3=0, pc_wr_valid=1, pc_wr_data = data.
- With no grant: write_enable3=0 and pc_wr_valid=0. Address/data hold their previous values (don't-care).

Scoreboard:
- Clear on commit: the bit for write_adress3 is cleared at the edge ending cycle N+1. busy reads 0 from cycle N+2.
- rsv_ready = rsv_valid && (rsv_addr==15 || !busy[rsv_addr]) && !flush.
  - A busy destination stalls the issue stage (WAW guard).
  - R15 reservations are accepted and not tracked.
- Simultaneous commit clear and reservation of the same register: busy is still 1, so rsv_ready=0. The reservation succeeds next cycle.
- A commit to a register that is not busy is legal; the bit stays 0.
- flush: all busy bits go to 0 at the next edge and rsv_ready=0 that cycle. Flush has priority over a same-cycle set.
  - The write stage and arbitration are unaffected; in-flight writes still commit.
- rd_hazard[k] = (read_adress_k != 15) && busy[read_adress_k]. It is combinational and has no bypass from the write stage.

Width rules:
- Index fields use $clog2(N_REQ).
- Data passes through unmodified.

Decomposition:
Package sm_rf_pkg holds:
- ADDR_W, DATA_W
- PC_REG = 4'd15
- NUM_GPR = 15
- typedef wb_req_t {addr, data}

Sub-module sm_rr_arbiter (parameter N; inputs req and ptr; outputs one-hot grant and grant index). It is combinational and is reused by the memory-port arbiter later. Pointer update stays in the top level.

Test Plan:
1. Reset: drive rst_n=0 mid-transfer → write_enable3=0, busy=0, pc_wr_valid=0 immediately; after release, req0 valid addr=3 data=0xA5A5A5A5 → write_enable3=1, write_adress3=3, data 0xA5A5A5A5 one cycle after the grant.
2. Round robin: all 3 requesters valid continuously, addrs 1/2/3 → grants cycle 0,1,2,0,1,2. With only req2 dropped → grants alternate 0,1. No requester waits more than 3 cycles.
3. Scoreboard: reserve R5 → busy[5]=1; rd_hazard[0]=1 with read_adress0=5; second reserve of R5 → rsv_ready=0; req1 writes R5 → busy[5]=0 two cycles after the grant and rsv_ready=1 on retry.
4. Same-cycle collision: commit R7 and reserve R7 in the same cycle → rsv_ready=0; next cycle rsv_ready=1 and busy[7]=1.
5. R15: req0 writes addr=15 data=0x00000100 → pc_wr_valid=1, pc_wr_data=0x100, write_enable3=0. Reserve R15 → rsv_ready=1 and busy unchanged. read_adress1=15 → rd_hazard[1]=0.
6. Flush: busy R1,R2,R9 set, assert flush together with a reserve of R4 → rsv_ready=0 and busy=0 next cycle; an in-flight write to R2 still produces write_enable3=1.
